// File: rtl/wb_queue_if.sv
// Bundle of the two writeback sources, the register-file write port and the
// forwarding snoop port that surround the writeback queue.
interface wb_queue_if #(parameter int DEPTH = 4) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          a_valid;
  logic [4:0]    a_reg;
  logic [31:0]   a_data;
  logic          b_valid;
  logic [4:0]    b_reg;
  logic [31:0]   b_data;
  logic          b_ready;
  logic          regwrite;
  logic [4:0]    wreg;
  logic [31:0]   wdata;
  logic [4:0]    rreg1;
  logic [4:0]    rreg2;
  logic          hit1;
  logic          hit2;
  logic [31:0]   fwd1;
  logic [31:0]   fwd2;
  logic [CW-1:0] count;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, rreg1, rreg2,
    output b_ready, regwrite, wreg, wdata, hit1, hit2, fwd1, fwd2, count
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, rreg1, rreg2,
    input  b_ready, regwrite, wreg, wdata, hit1, hit2, fwd1, fwd2, count
  );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue merging pipeline (A) and long-latency (B) results
// into one register-file write port, with forwarding of still-pending writes.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input logic   clk,
  input logic   reset,
  wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    ent_reg  [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] b_slot;
  logic [AW-1:0] idx;
  logic [CW-1:0] count;
  logic          deq;
  logic          acc_a;
  logic          acc_b;
  logic          b_ready;

  // Writes to r0 are dropped here; B still handshakes so its unit is released.
  always_comb begin
    deq     = (count != '0);
    b_ready = (count != CW'(DEPTH));
    acc_a   = bus.a_valid && (bus.a_reg != 5'd0);
    acc_b   = bus.b_valid && b_ready && (bus.b_reg != 5'd0);
    b_slot  = wr_ptr + AW'(acc_a);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(deq);
      wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
      count  <= count - CW'(deq) + CW'(acc_a) + CW'(acc_b);
    end
  end

  // Entry payloads need no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (acc_a) begin
      ent_reg[wr_ptr]  <= bus.a_reg;
      ent_data[wr_ptr] <= bus.a_data;
    end
    if (acc_b) begin
      ent_reg[b_slot]  <= bus.b_reg;
      ent_data[b_slot] <= bus.b_data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    bus.hit1 = 1'b0;
    bus.hit2 = 1'b0;
    bus.fwd1 = '0;
    bus.fwd2 = '0;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (CW'(i) < count) begin
        if (bus.rreg1 != 5'd0 && ent_reg[idx] == bus.rreg1) begin
          bus.hit1 = 1'b1;
          bus.fwd1 = ent_data[idx];
        end
        if (bus.rreg2 != 5'd0 && ent_reg[idx] == bus.rreg2) begin
          bus.hit2 = 1'b1;
          bus.fwd2 = ent_data[idx];
        end
      end
    end
  end

  always_comb begin
    bus.b_ready  = b_ready;
    bus.count    = count;
    bus.regwrite = deq;
    bus.wreg     = deq ? ent_reg[rd_ptr]  : 5'd0;
    bus.wdata    = deq ? ent_data[rd_ptr] : 32'd0;
  end
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic, all checked
// against a queue-of-entries reference model.
module tb_wb_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } entry_t;

  logic clk;
  logic reset;
  entry_t model[$];
  int checkCount;
  int passCount;
  int failCount;

  wb_queue_if #(.DEPTH(DEPTH)) bus ();

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived purely from the list of pending writes.
  task automatic checkOutput();
    logic        eHit1, eHit2;
    logic [31:0] eFwd1, eFwd2;
    eHit1 = 1'b0; eHit2 = 1'b0; eFwd1 = '0; eFwd2 = '0;
    for (int i = model.size() - 1; i >= 0; i--) begin
      if (!eHit1 && bus.rreg1 != 0 && model[i].r == bus.rreg1) begin
        eHit1 = 1'b1; eFwd1 = model[i].d;
      end
      if (!eHit2 && bus.rreg2 != 0 && model[i].r == bus.rreg2) begin
        eHit2 = 1'b1; eFwd2 = model[i].d;
      end
    end
    checkValue("regwrite", 32'(bus.regwrite), 32'(model.size() != 0));
    checkValue("wreg", 32'(bus.wreg), model.size() != 0 ? 32'(model[0].r) : 32'd0);
    checkValue("wdata", bus.wdata, model.size() != 0 ? model[0].d : 32'd0);
    checkValue("b_ready", 32'(bus.b_ready), 32'(model.size() != DEPTH));
    checkValue("count", 32'(bus.count), 32'(model.size()));
    checkValue("hit1", 32'(bus.hit1), 32'(eHit1));
    checkValue("hit2", 32'(bus.hit2), 32'(eHit2));
    checkValue("fwd1", bus.fwd1, eFwd1);
    checkValue("fwd2", bus.fwd2, eFwd2);
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br, input logic [31:0] bd,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    bus.rreg1 = r1; bus.rreg2 = r2;
    #1 checkOutput();
  endtask

  // One rising edge: retire the head, then append A before B.
  task automatic tick();
    int sizeBefore;
    @(posedge clk);
    sizeBefore = model.size();
    if (sizeBefore != 0) void'(model.pop_front());
    if (bus.a_valid && bus.a_reg != 0) model.push_back('{bus.a_reg, bus.a_data});
    if (bus.b_valid && sizeBefore != DEPTH && bus.b_reg != 0)
      model.push_back('{bus.b_reg, bus.b_data});
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    tick();
  endtask

  initial begin
    checkCount = 0; passCount = 0; failCount = 0;
    reset = 1'b0;
    bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
    bus.rreg1 = '0; bus.rreg2 = '0;
    #1 checkOutput();
    checkValue("reset_b_ready", 32'(bus.b_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Single A write, seen on the write port and via forwarding next cycle.
    applyStimulus(1'b1, 5'd1, 32'd14, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    checkValue("single_wreg", 32'(bus.wreg), 32'd1);
    checkValue("single_wdata", bus.wdata, 32'd14);
    checkValue("single_fwd1", bus.fwd1, 32'd14);
    tick();
    idle(5'd1, 5'd0);
    checkValue("single_drained", 32'(bus.count), 32'd0);

    // Same destination from A and B together: A retires first, B forwards.
    applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    checkValue("dual_first_wdata", bus.wdata, 32'hAAAA);
    checkValue("dual_fwd_both", bus.fwd1, 32'hBBBB);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    checkValue("dual_second_wdata", bus.wdata, 32'hBBBB);
    checkValue("dual_fwd_b_only", bus.fwd1, 32'hBBBB);
    tick();
    idle(5'd3, 5'd0);

    // Backpressure: both sources every cycle until B stalls at full.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 32'(100 + i), 1'b1, 5'(i + 10), 32'(200 + i),
                    5'(i + 1), 5'(i + 9));
      tick();
    end
    applyStimulus(1'b1, 5'd20, 32'd300, 1'b1, 5'd21, 32'd301, 5'd0, 5'd0);
    checkValue("bp_count_full", 32'(bus.count), 32'd4);
    checkValue("bp_b_ready_low", 32'(bus.b_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) idle(5'(i + 10), 5'd20);

    // Register zero is never queued or forwarded.
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    checkValue("r0_count", 32'(bus.count), 32'd0);

    // Asynchronous reset in the middle of a full-ish queue.
    applyStimulus(1'b1, 5'd4, 32'd40, 1'b1, 5'd5, 32'd50, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd6, 32'd60, 1'b1, 5'd7, 32'd70, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.rreg1 = 5'd6; bus.rreg2 = 5'd7;
    #1 checkValue("pre_reset_count", 32'(bus.count), 32'd3);
    #1 reset = 1'b0;
    #1 model.delete();
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(5'd6, 5'd7);
    idle(5'd6, 5'd7);

    // Ten single writes to exercise pointer wrap-around.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i * 2), 1'b0, 5'd0, 32'd0, 5'(i - 1), 5'(i));
      if (i > 1) checkValue("wrap_wdata", bus.wdata, 32'((i - 1) * 2));
      tick();
    end
    idle(5'd10, 5'd0);
    idle(5'd0, 5'd0);

    // Random traffic over a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end
    for (int i = 0; i < 5; i++) idle(5'd1, 5'd2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of pending-write entries (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  pipeline writeback request; always accepted, no ready.
REQ-005 a_reg  input  5  destination register of source A.
REQ-006 a_data  input  32  write data of source A.
REQ-007 b_valid  input  1  long-latency unit (mult/div) writeback request.
REQ-008 b_reg  input  5  destination register of source B.
REQ-009 b_data  input  32  write data of source B.
REQ-010 b_ready  output  1  source B accepted on edge where b_valid && b_ready.
REQ-011 regwrite  output  1  write strobe to register file.
REQ-012 wreg  output  5  register file write address.
REQ-013 wdata  output  32  register file write data.
REQ-014 rreg1, rreg2  input  5 each  register file read addresses, snooped for forwarding.
REQ-015 hit1, hit2  output  1 each  pending write exists for rreg1/rreg2.
REQ-016 fwd1, fwd2  output  32 each  forwarded data for rreg1/rreg2.
REQ-017 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-018 Block SHALL be an in-order FIFO of (reg, data) entries draining into the register file write port.
REQ-019 regwrite SHALL equal (count != 0); wreg/wdata SHALL show head entry, 0 when empty (combinational from state).
REQ-020 Head SHALL be dequeued on every rising edge where regwrite is 1 (register file consumes one write per cycle).
REQ-021 Enqueue latency: request accepted at edge N appears on regwrite in cycle after N at earliest, regfile updated at edge N+1.
REQ-022 a_valid SHALL enqueue on every edge; A never dropped, never stalled.
REQ-023 b_ready SHALL equal (count != DEPTH); B enqueued on edge with b_valid && b_ready.
REQ-024 Simultaneous A and B acceptance: A SHALL occupy the older slot, B the younger (A retires first).
REQ-025 Simultaneous enqueue and dequeue SHALL be legal; next count = count - deq + accA + accB.
REQ-026 Occupancy SHALL never exceed DEPTH under any input sequence (guaranteed by REQ-023 rule).
REQ-027 Requests with reg == 0 SHALL be discarded, not enqueued; B handshake still completes (b_ready unaffected).
REQ-028 hitN SHALL be 1 iff rregN != 0 and any queued entry has reg == rregN; entries arriving this cycle not included.
REQ-029 fwdN SHALL be data of youngest matching queued entry; 0 when hitN is 0.
REQ-030 Head entry being written this cycle SHALL be included in forwarding (regfile write not yet visible).
REQ-031 Read/write pointers SHALL wrap modulo DEPTH without bubbles.

Reset
REQ-032 reset low SHALL immediately (asynchronously) clear count and pointers, invalidating all entries.
REQ-033 During/after reset: regwrite=0, wreg=0, wdata=0, hit1=hit2=0, fwd1=fwd2=0, b_ready=1, count=0.
REQ-034 Reset mid-operation SHALL drop all pending writes; no regwrite pulse after reset asserts.
REQ-035 First enqueue permitted on first rising edge after reset deasserts.

Verification
REQ-036 Single A write: a_valid=1, a_reg=1, a_data=14 for one edge -> next cycle regwrite=1, wreg=1, wdata=14, hit1=1/fwd1=14 with rreg1=1; following cycle regwrite=0, count=0.
REQ-037 Simultaneous A(reg 3, 0xAAAA) and B(reg 3, 0xBBBB) -> writes issue A then B on consecutive cycles; fwd for rreg1=3 shows 0xBBBB while both queued, then 0xBBBB while only B queued.
REQ-038 Backpressure (DEPTH=4): hold b_valid=1 with a_valid=1 every cycle -> count saturates at 4, b_ready=0 while count=4, no A request lost, writes retire in acceptance order.
REQ-039 Register zero: a_reg=0, a_data=0xFFFF -> no regwrite, count stays 0; rreg1=0 -> hit1=0.
REQ-040 Reset mid-operation: fill 3 entries, pull reset low between edges -> regwrite, count, hit1, hit2 go to 0 without clock edge; no stale write after release.
REQ-041 Pointer wrap: stream 10 single A writes (regs 1..10, data=reg*2) -> regfile sequence matches exactly, count never exceeds 1.
